deser_enqueue_sched: RTL

//  Arbitrates two serial-deserializer producers into one shared byte queue, all on clk_1MHz.

---
 rtl/deser_enqueue_sched.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/deser_enqueue_sched.sv
// deser_enqueue_sched: arbitrates two deserializer producers into one shared
// byte queue. Generates the producer tick (clk_1MHz / DIV_PROD) and queue tick
// (clk_1MHz / DIV_QUEUE) and sequences grant -> latch -> enqueue -> ack -> release.
// Optional feature macro: RR_ARB_EN (round-robin arbitration). When undefined,
// producer 0 has fixed priority.
module deser_enqueue_sched #(
  parameter int DATA_W      = 8,
  parameter int DIV_PROD    = 10,
  parameter int DIV_QUEUE   = 100,
  parameter int QUEUE_DEPTH = 8
) (
  input  logic              clk_1MHz,
  input  logic              reset,
  input  logic [DATA_W-1:0] p0_data,
  input  logic              p0_ready,
  output logic              p0_ack,
  input  logic [DATA_W-1:0] p1_data,
  input  logic              p1_ready,
  output logic              p1_ack,
  input  logic [7:0]        q_len,
  output logic [DATA_W-1:0] q_data,
  output logic              q_enqueue,
  output logic              tick_prod,
  output logic              tick_queue,
  output logic [1:0]        grant,
  output logic              busy
);

  localparam int PC_W = (DIV_PROD  > 1) ? $clog2(DIV_PROD)  : 1;
  localparam int QC_W = (DIV_QUEUE > 1) ? $clog2(DIV_QUEUE) : 1;
  localparam logic [PC_W-1:0] PROD_LAST  = PC_W'(DIV_PROD - 1);
  localparam logic [QC_W-1:0] QUEUE_LAST = QC_W'(DIV_QUEUE - 1);
  localparam logic [7:0]      DEPTH      = 8'(QUEUE_DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_Q  = 3'd1,
    ENQ     = 3'd2,
    WAIT_A  = 3'd3,
    ACK     = 3'd4,
    RELEASE = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   prod_cnt_q, prod_cnt_d;
  logic [QC_W-1:0]   queue_cnt_q, queue_cnt_d;
  logic              tick_prod_q, tick_prod_d;
  logic              tick_queue_q, tick_queue_d;
  logic [1:0]        grant_q, grant_d;
  logic [DATA_W-1:0] q_data_q, q_data_d;
  logic              q_enqueue_q, q_enqueue_d;
  logic              p0_ack_q, p0_ack_d;
  logic              p1_ack_q, p1_ack_d;
  logic              busy_q, busy_d;
  logic              win_p1_s;
  logic              own_ready_s;
`ifdef RR_ARB_EN
  logic              rr_ptr_q, rr_ptr_d;
`endif

  // Free-running dividers; the tick flops are high exactly while the count sits at DIV-1.
  always_comb begin
    if (prod_cnt_q == PROD_LAST) begin
      prod_cnt_d = '0;
    end else begin
      prod_cnt_d = prod_cnt_q + PC_W'(1);
    end
    if (queue_cnt_q == QUEUE_LAST) begin
      queue_cnt_d = '0;
    end else begin
      queue_cnt_d = queue_cnt_q + QC_W'(1);
    end
    tick_prod_d  = (prod_cnt_d == PROD_LAST);
    tick_queue_d = (queue_cnt_d == QUEUE_LAST);
  end

  // Arbitration winner and the ready line of the current owner.
  always_comb begin
`ifdef RR_ARB_EN
    win_p1_s = p1_ready && (!p0_ready || rr_ptr_q);
`else
    win_p1_s = p1_ready && !p0_ready;
`endif
    if (grant_q[1]) begin
      own_ready_s = p1_ready;
    end else begin
      own_ready_s = p0_ready;
    end
  end

  // Transfer sequencer: next state and registered outputs; each state reacts only to its own tick.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    q_data_d    = q_data_q;
    q_enqueue_d = q_enqueue_q;
    p0_ack_d    = p0_ack_q;
    p1_ack_d    = p1_ack_q;
`ifdef RR_ARB_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (tick_prod_q && (p0_ready || p1_ready) && (q_len < DEPTH)) begin
          state_d = WAIT_Q;
          if (win_p1_s) begin
            grant_d  = 2'b10;
            q_data_d = p1_data;
          end else begin
            grant_d  = 2'b01;
            q_data_d = p0_data;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_Q: begin
        if (tick_queue_q) begin
          state_d     = ENQ;
          q_enqueue_d = 1'b1;
        end else begin
          state_d = WAIT_Q;
        end
      end
      ENQ: begin
        if (tick_queue_q) begin
          state_d     = WAIT_A;
          q_enqueue_d = 1'b0;
        end else begin
          state_d = ENQ;
        end
      end
      WAIT_A: begin
        if (tick_prod_q) begin
          state_d  = ACK;
          p0_ack_d = grant_q[0];
          p1_ack_d = grant_q[1];
        end else begin
          state_d = WAIT_A;
        end
      end
      ACK: begin
        if (tick_prod_q) begin
          state_d  = RELEASE;
          p0_ack_d = 1'b0;
          p1_ack_d = 1'b0;
`ifdef RR_ARB_EN
          // Next contested grant goes to the producer that was not just served.
          rr_ptr_d = grant_q[0];
`endif
        end else begin
          state_d = ACK;
        end
      end
      RELEASE: begin
        // Owner must drop ready before another transfer can start (no double enqueue).
        if (!own_ready_s) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end else begin
          state_d = RELEASE;
        end
      end
      default: begin
        state_d     = IDLE;
        grant_d     = 2'b00;
        q_enqueue_d = 1'b0;
        p0_ack_d    = 1'b0;
        p1_ack_d    = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any transfer in progress.
  always_ff @(posedge clk_1MHz or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      prod_cnt_q   <= '0;
      queue_cnt_q  <= '0;
      tick_prod_q  <= 1'b0;
      tick_queue_q <= 1'b0;
      grant_q      <= 2'b00;
      q_data_q     <= '0;
      q_enqueue_q  <= 1'b0;
      p0_ack_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      busy_q       <= 1'b0;
`ifdef RR_ARB_EN
      rr_ptr_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      prod_cnt_q   <= prod_cnt_d;
      queue_cnt_q  <= queue_cnt_d;
      tick_prod_q  <= tick_prod_d;
      tick_queue_q <= tick_queue_d;
      grant_q      <= grant_d;
      q_data_q     <= q_data_d;
      q_enqueue_q  <= q_enqueue_d;
      p0_ack_q     <= p0_ack_d;
      p1_ack_q     <= p1_ack_d;
      busy_q       <= busy_d;
`ifdef RR_ARB_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end

  assign tick_prod  = tick_prod_q;
  assign tick_queue = tick_queue_q;
  assign grant      = grant_q;
  assign q_data     = q_data_q;
  assign q_enqueue  = q_enqueue_q;
  assign p0_ack     = p0_ack_q;
  assign p1_ack     = p1_ack_q;
  assign busy       = busy_q;

endmodule
